// File: rtl/wb_ddr3_responder_model.sv
// Pipelined Wishbone responder standing in for ddr3_top: init stall, fixed-latency
// in-order acks, byte-strobed RAM, aux echo and bus abort.
module wb_ddr3_responder_model #(
  parameter int ADDR_BITS     = 24,
  parameter int MEM_BITS      = 8,
  parameter int DATA_BITS     = 512,
  parameter int AUX_WIDTH     = 4,
  parameter int LATENCY       = 4,
  parameter int INIT_CYCLES   = 16,
  parameter int STALL_EVERY   = 0,
  parameter int STALL_CYCLES  = 2,
  parameter int OPT_BUS_ABORT = 1
) (
  input  logic                   i_controller_clk,
  input  logic                   i_rst,
  input  logic                   i_wb_cyc,
  input  logic                   i_wb_stb,
  input  logic                   i_wb_we,
  input  logic [ADDR_BITS-1:0]   i_wb_addr,
  input  logic [DATA_BITS-1:0]   i_wb_data,
  input  logic [DATA_BITS/8-1:0] i_wb_sel,
  input  logic [AUX_WIDTH-1:0]   i_aux,
  output logic                   o_wb_stall,
  output logic                   o_wb_ack,
  output logic [DATA_BITS-1:0]   o_wb_data,
  output logic [AUX_WIDTH-1:0]   o_aux
);

  localparam int SEL_BITS = DATA_BITS / 8;
  localparam int DEPTH    = 1 << MEM_BITS;

  typedef enum logic [1:0] {S_INIT, S_READY, S_STALL} state_t;

  state_t        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   acc_q, acc_d;
  logic          stall_q;
  logic          accept;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [MEM_BITS-1:0]  idx;
  logic [DATA_BITS-1:0] rd_data;

  logic [LATENCY-1:0]   vld_q;
  logic [DATA_BITS-1:0] dat_q [LATENCY];
  logic [AUX_WIDTH-1:0] aux_q [LATENCY];

  logic unused_addr;

  assign idx         = i_wb_addr[MEM_BITS-1:0];
  assign rd_data     = mem[idx];
  assign accept      = i_wb_cyc && i_wb_stb && !stall_q && !i_rst;
  assign unused_addr = ^{1'b0, i_wb_addr};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    unique case (state_q)
      S_INIT: begin
        if (cnt_q == 32'(INIT_CYCLES)) begin
          state_d = S_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_READY: begin
        if (accept) begin
          acc_d = acc_q + 32'd1;
          if (STALL_EVERY != 0 && acc_d == 32'(STALL_EVERY)) begin
            state_d = S_STALL;
            acc_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      S_STALL: begin
        if (cnt_q == 32'(STALL_CYCLES - 1)) begin
          state_d = S_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge i_controller_clk) begin
    if (i_rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      acc_q   <= '0;
      stall_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      stall_q <= (state_d != S_READY);
    end
  end

  // RAM has no reset so contents survive i_rst
  always_ff @(posedge i_controller_clk) begin
    if (accept && i_wb_we) begin
      for (int unsigned i = 0; i < SEL_BITS; i++) begin
        if (i_wb_sel[i]) mem[idx][8*i +: 8] <= i_wb_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge i_controller_clk) begin
    if (i_rst || (OPT_BUS_ABORT != 0 && !i_wb_cyc)) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= accept;
      for (int unsigned i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Write acks carry zero data, so the we bit is folded into the data at entry
  always_ff @(posedge i_controller_clk) begin
    dat_q[0] <= i_wb_we ? '0 : rd_data;
    aux_q[0] <= i_aux;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      dat_q[i] <= dat_q[i-1];
      aux_q[i] <= aux_q[i-1];
    end
  end

  assign o_wb_stall = stall_q;
  assign o_wb_ack   = vld_q[LATENCY-1];
  assign o_wb_data  = vld_q[LATENCY-1] ? dat_q[LATENCY-1] : '0;
  assign o_aux      = vld_q[LATENCY-1] ? aux_q[LATENCY-1] : '0;

endmodule

// File: tb/tb_wb_ddr3_responder_model.sv
// Randomized scoreboard bench for wb_ddr3_responder_model against a byte-level
// memory model and an accept/stall countdown model.
module tb_wb_ddr3_responder_model;

  localparam int AW  = 24;
  localparam int MB  = 8;
  localparam int DW  = 64;
  localparam int SW  = DW / 8;
  localparam int XW  = 4;
  localparam int LAT = 4;
  localparam int INI = 8;
  localparam int SE  = 4;
  localparam int SC  = 2;
  localparam int NW  = 1 << MB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cyc = 1'b0;
  logic          stb = 1'b0;
  logic          we  = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [SW-1:0] sel = '0;
  logic [XW-1:0] aux = '0;
  logic          o_stall, o_ack;
  logic [DW-1:0] o_data;
  logic [XW-1:0] o_aux;

  wb_ddr3_responder_model #(
    .ADDR_BITS(AW), .MEM_BITS(MB), .DATA_BITS(DW), .AUX_WIDTH(XW),
    .LATENCY(LAT), .INIT_CYCLES(INI), .STALL_EVERY(SE), .STALL_CYCLES(SC),
    .OPT_BUS_ABORT(1)
  ) dut (
    .i_controller_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb),
    .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
    .i_aux(aux), .o_wb_stall(o_stall), .o_wb_ack(o_ack), .o_wb_data(o_data),
    .o_aux(o_aux)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   ack_edge;
    logic [DW-1:0] data;
    logic [XW-1:0] aux;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] mem_m [NW];
  int unsigned   edge_cnt = 0;
  int            total = 0, bad = 0;
  int            accepts = 0, acks = 0, flushed = 0;
  bit            armed = 1'b0;
  bit            exp_stall = 1'b1;
  int            phase = 0;      // 0 init, 1 ready, 2 injected stall
  int            remain = 0;
  int            run_acc = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: compares stall every cycle and pops one expectation per ack
  always @(negedge clk) begin
    if (armed) begin
      total++;
      if (o_stall !== exp_stall) begin
        bad++;
        $display("FAIL stall edge=%0d got=%b exp=%b", edge_cnt, o_stall, exp_stall);
      end
      if (o_ack === 1'b1) begin
        acks++;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ack edge=%0d got=ack exp=none", edge_cnt);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.ack_edge != edge_cnt || o_data !== e.data || o_aux !== e.aux) begin
            bad++;
            $display("FAIL ack edge got=%0d exp=%0d data got=%h exp=%h aux got=%h exp=%h",
                     edge_cnt, e.ack_edge, o_data, e.data, o_aux, e.aux);
          end
        end
      end else begin
        total++;
        if (o_ack !== 1'b0 || o_data !== '0 || o_aux !== '0) begin
          bad++;
          $display("FAIL idle_outputs edge=%0d got ack=%b data=%h aux=%h exp=0",
                   edge_cnt, o_ack, o_data, o_aux);
        end
      end
    end
  end

  task automatic step(input bit r, input bit c, input bit s, input bit w,
                      input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] m, input logic [XW-1:0] x,
                      output bit acc);
    int unsigned k1;
    int unsigned ix;
    @(negedge clk);
    #1;
    rst = r; cyc = c; stb = s; we = w; addr = a; wdata = d; sel = m; aux = x;
    acc = !r && c && s && !o_stall;
    k1 = edge_cnt + 1;
    if (r || !c) begin
      while (q.size() > 0 && q[q.size()-1].ack_edge >= k1) begin
        void'(q.pop_back());
        flushed++;
      end
    end
    if (acc) begin
      exp_t e;
      accepts++;
      ix = a % NW;
      if (w) begin
        for (int b = 0; b < SW; b++)
          if (m[b]) mem_m[ix][8*b +: 8] = d[8*b +: 8];
      end
      e.ack_edge = k1 + LAT - 1;
      e.data     = w ? '0 : mem_m[ix];
      e.aux      = x;
      q.push_back(e);
    end
    if (r) begin
      phase = 0; remain = INI; run_acc = 0;
    end else if (phase == 0) begin
      if (remain == 0) phase = 1; else remain--;
    end else if (phase == 1) begin
      if (acc) begin
        run_acc++;
        if (run_acc % SE == 0) begin
          phase = 2; remain = SC - 1;
        end
      end
    end else begin
      if (remain == 0) phase = 1; else remain--;
    end
    exp_stall = (phase != 1);
    armed = 1'b1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, '0, '0, '0, '0, acc);
  endtask

  task automatic req(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [SW-1:0] m, input logic [XW-1:0] x);
    bit acc;
    acc = 0;
    for (int t = 0; t < 40 && !acc; t++) step(0, 1, 1, w, a, d, m, x, acc);
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL accept_timeout addr=%h got=stalled exp=accepted", a);
    end
  endtask

  initial begin
    bit acc;
    int stall_seen;
    logic [DW-1:0] pat;

    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, '0, '0, '0, '0, acc);
    step(0, 1, 0, 0, '0, '0, '0, '0, acc);
    stall_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0, 0, '0, '0, '0, '0, acc);
      if (o_stall) stall_seen++;
    end
    total++;
    if (stall_seen != INI) begin
      bad++;
      $display("FAIL init_stall_len got=%0d exp=%0d", stall_seen, INI);
    end

    for (int i = 0; i < NW; i++)
      req(1, AW'(i), {$urandom, $urandom}, '1, XW'(i));

    for (int i = 0; i < 4; i++) begin
      pat = {SW{8'(i * 8'h11)}};
      req(1, AW'(i), pat, '1, XW'(i));
    end
    for (int i = 0; i < 4; i++) req(0, AW'(i), '0, '0, XW'(i));

    req(1, AW'(7), '1, '1, 4'h7);
    req(1, AW'(7), '0, SW'(1), 4'h8);
    req(0, AW'(7), '0, '0, 4'h9);

    req(1, AW'(5), {SW{8'hA5}}, '1, 4'hA);
    req(0, AW'(261), '0, '0, 4'hB);

    for (int i = 0; i < 14; i++) step(0, 1, 1, 0, AW'(i), '0, '0, XW'(i), acc);

    req(0, AW'(0), '0, '0, 4'h1);
    req(0, AW'(1), '0, '0, 4'h2);
    req(0, AW'(2), '0, '0, 4'h3);
    step(0, 0, 0, 0, '0, '0, '0, '0, acc);
    req(0, AW'(2), '0, '0, 4'h4);
    idle(LAT + 2);

    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 3) step(0, 0, $urandom_range(0, 1) == 1, 0, '0, '0, '0, '0, acc);
      else if (r < 20) idle(1);
      else req($urandom_range(0, 1) == 1, AW'($urandom), {$urandom, $urandom},
               SW'($urandom), XW'($urandom));
    end

    req(0, AW'(3), '0, '0, 4'hC);
    req(0, AW'(4), '0, '0, 4'hD);
    step(1, 1, 0, 0, '0, '0, '0, '0, acc);
    step(0, 1, 0, 0, '0, '0, '0, '0, acc);
    idle(INI + 2);
    req(0, AW'(261), '0, '0, 4'hE);

    for (int t = 0; t < 50 && q.size() > 0; t++) idle(1);
    idle(2);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end
    total++;
    if (acks != accepts - flushed) begin
      bad++;
      $display("FAIL ack_count got=%0d exp=%0d", acks, accepts - flushed);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
